user_id_bank: RTL



---
 rtl/user_id_pkg.sv | 15 +
 rtl/conb_1.sv | 13 +
 rtl/user_id_const_word.sv | 24 ++
 rtl/user_id_bank.sv | 137 +++++++++++++
 4 files changed

// File: rtl/user_id_pkg.sv
// Shared types for the user-ID bank: controller state encoding and index-width helper.
package user_id_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      SCAN = 2'd2
   } state_t;

   // Wide enough to name every word, the checksum slot and one out-of-range index.
   function automatic int idx_width(input int n_words);
      return $clog2(n_words + 2);
   endfunction

endpackage

// File: rtl/conb_1.sv
// Behavioural stand-in for the standard-cell tie-off (HI follows VPWR, LO follows VGND).
// Leave this file out when linking against the real cell library.
module conb_1 (
   inout  wire VPWR,
   inout  wire VGND,
   output wire HI,
   output wire LO
);

   assign HI = VPWR;
   assign LO = VGND;

endmodule

// File: rtl/user_id_const_word.sv
// One hard-wired ID word: one tie cell per bit, the VALUE bit picks the HI or LO output.
module user_id_const_word #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] VALUE = '0
) (
   inout  wire              VPWR,
   inout  wire              VGND,
   output logic [WIDTH-1:0] word
);

   wire [WIDTH-1:0] hi;
   wire [WIDTH-1:0] lo;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      conb_1 u_tie (
         .VPWR (VPWR),
         .VGND (VGND),
         .HI   (hi[i]),
         .LO   (lo[i])
      );
      assign word[i] = VALUE[i] ? hi[i] : lo[i];
   end

endmodule

// File: rtl/user_id_bank.sv
// Bank of tied-off user-ID words: indexed valid/ready reads (1-cycle latency, one outstanding) and an LSB-first serial scan.
// USER_ID_CHECKSUM_EN adds an XOR checksum word at index N_WORDS and at the tail of the scan stream.
module user_id_bank
   import user_id_pkg::*;
#(
   parameter int                         N_WORDS         = 4,
   parameter int                         WIDTH           = 32,
   parameter logic [N_WORDS*WIDTH-1:0]   USER_PROJECT_ID = '0,
   localparam int                        IDX_W           = idx_width(N_WORDS)
) (
   input  logic             axi_clk,
   input  logic             axi_reset_n,
   inout  wire              VPWR,
   inout  wire              VGND,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IDX_W-1:0] req_idx,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   input  logic             scan_start,
   output logic             scan_busy,
   output logic             scan_sdo,
   output logic             scan_done,
   output logic [WIDTH-1:0] id_word0
);

`ifdef USER_ID_CHECKSUM_EN
   localparam int N_SLOTS = N_WORDS + 1;
`else
   localparam int N_SLOTS = N_WORDS;
`endif
   localparam int               TOTAL    = N_SLOTS * WIDTH;
   localparam int               CNT_W    = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);

   logic [N_WORDS*WIDTH-1:0] words;
   logic [N_SLOTS*WIDTH-1:0] id_flat;

   for (genvar k = 0; k < N_WORDS; k++) begin : g_word
      user_id_const_word #(
         .WIDTH (WIDTH),
         .VALUE (USER_PROJECT_ID[k*WIDTH +: WIDTH])
      ) u_word (
         .VPWR (VPWR),
         .VGND (VGND),
         .word (words[k*WIDTH +: WIDTH])
      );
   end

`ifdef USER_ID_CHECKSUM_EN
   logic [WIDTH-1:0] csum;
   always_comb begin
      csum = '0;
      for (int k = 0; k < N_WORDS; k++) csum ^= words[k*WIDTH +: WIDTH];
   end
   assign id_flat = {csum, words};
`else
   assign id_flat = words;
`endif

   assign id_word0 = words[WIDTH-1:0];

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             last_bit;
   logic             req_hs;
   logic [WIDTH-1:0] rd_word;
   logic             sdo_nxt;

   assign last_bit = (bit_cnt == LAST_BIT);
   assign req_hs   = req_valid & req_ready;

   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) state <= IDLE;
      else              state <= state_nxt;
   end

   // scan_start wins over a same-cycle request; the request simply stays pending.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (scan_start)     state_nxt = SCAN;
            else if (req_valid) state_nxt = RESP;
         end
         RESP:    if (rsp_ready) state_nxt = IDLE;
         SCAN:    if (last_bit)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE) & ~scan_start;
      rsp_valid = (state == RESP);
      scan_busy = (state == SCAN);
   end

   always_comb begin
      rd_word = WIDTH'(id_flat >> (int'(req_idx) * WIDTH));
      cnt_nxt = (state == SCAN) ? bit_cnt + CNT_W'(1) : '0;
      sdo_nxt = 1'(id_flat >> cnt_nxt);
   end

   always_ff @(posedge axi_clk) begin
      if (!axi_reset_n) begin
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         bit_cnt   <= '0;
         scan_sdo  <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= (state == SCAN) & last_bit;
         if (req_hs) begin
            if (req_idx < IDX_W'(N_SLOTS)) begin
               rsp_data <= rd_word;
               rsp_err  <= 1'b0;
            end else begin
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end
         // bit_cnt always names the bit currently on scan_sdo.
         if (state_nxt == SCAN) begin
            bit_cnt  <= cnt_nxt;
            scan_sdo <= sdo_nxt;
         end else begin
            bit_cnt  <= '0;
            scan_sdo <= 1'b0;
         end
      end
   end

endmodule
